seq_match_fsm: RTL and testbench

- Parametrised successor to the fixed 2-bit-input teaching FSM: a streaming sequence detector.
- Consumes one W-bit symbol per valid cycle and compares the last N symbols against a compile-time PATTERN.
- Pulses `hit` on each match and keeps a saturating match count; overlap or non-overlap match mode is selectable.
- Sits as a leaf block driven directly by the testbench or by upstream control logic.

---
 rtl/seq_match_fsm_sat_counter.sv | 31 +++
 rtl/seq_match_fsm.sv | 116 +++++++++++
 tb/tb_seq_match_fsm.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_match_fsm_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over increment. At the all-ones value the counter stops
// and does not wrap.
module sat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Count register: async reset, then clear > saturating increment > hold.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q <= CNT_ZERO;
    end else if (clr) begin
      q <= CNT_ZERO;
    end else if (inc && (q != CNT_MAX)) begin
      q <= q + CNT_ONE;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/seq_match_fsm.sv
// Streaming sequence detector.
// The last N valid symbols are compared against PATTERN. Symbol 0 is the
// oldest and sits in the MSBs. The newest symbol sits in the LSBs.
// The FSM state is the history shift register plus the fill count. No encoded
// state register exists. A match pulses hit one edge later and bumps a
// saturating counter.
module seq_match_fsm #(
  parameter int W       = 2,
  parameter int N       = 3,
  parameter     PATTERN = 6'b01_10_10,
  parameter int OVERLAP = 1,
  parameter int CNT_W   = 4
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic                   in_valid,
  input  logic [W-1:0]           in,
  input  logic                   cnt_clr,
  output logic                   hit,
  output logic [CNT_W-1:0]       cnt,
  output logic [$clog2(N+1)-1:0] fill
);

  localparam int FW = $clog2(N + 1);
  // History holds N-1 symbols. One dummy slot is kept when N=1 so the
  // vector never collapses to zero width.
  localparam int HN = (N > 1) ? (N - 1) : 1;

  localparam logic [W*N-1:0] PAT       = PATTERN;
  localparam logic [FW-1:0]  FILL_MAX  = FW'(N);
  localparam logic [FW-1:0]  FILL_THR  = FW'(N - 1);
  localparam logic [FW-1:0]  FILL_ZERO = FW'(0);
  localparam logic [FW-1:0]  FILL_ONE  = FW'(1);

  if ($bits(PATTERN) != W * N) begin : g_pattern_width_check
    $error("seq_match_fsm: PATTERN width %0d does not equal W*N = %0d",
           $bits(PATTERN), W * N);
  end

  logic [HN*W-1:0]     history_r;
  logic [(HN+1)*W-1:0] window_s;
  logic [W*N-1:0]      cand_s;
  logic                pat_eq_s;
  logic                match_s;

  // Extract symbol i from a packed vector. Index 0 is the oldest symbol (MSBs).
  function automatic logic [W-1:0] sym(input logic [W*N-1:0] p, input int i);
    return p[(N-1-i)*W +: W];
  endfunction

  assign window_s = {history_r, in};
  assign cand_s   = window_s[W*N-1:0];

  // Match decode: compare symbol-wise, gated by valid and enough history.
  always_comb begin
    pat_eq_s = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (sym(cand_s, i) != sym(PAT, i)) begin
        pat_eq_s = 1'b0;
      end else begin
        pat_eq_s = pat_eq_s;
      end
    end
    match_s = in_valid && (fill >= FILL_THR) && pat_eq_s;
  end

  // History shift register: the newest symbol enters at the LSB end on each
  // valid symbol.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      history_r <= {(HN*W){1'b0}};
    end else if (in_valid) begin
      history_r <= window_s[HN*W-1:0];
    end else begin
      history_r <= history_r;
    end
  end

  // Fill count: saturate at N. In non-overlap mode, drop to 0 after a hit so
  // the stale history can never contribute to the next match.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      fill <= FILL_ZERO;
    end else if (in_valid) begin
      if (match_s && (OVERLAP == 0)) begin
        fill <= FILL_ZERO;
      end else if (fill == FILL_MAX) begin
        fill <= FILL_MAX;
      end else begin
        fill <= fill + FILL_ONE;
      end
    end else begin
      fill <= fill;
    end
  end

  // Registered hit pulse, one edge after the completing symbol.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hit <= 1'b0;
    end else begin
      hit <= match_s;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .clr_n (clr_n),
    .clr   (cnt_clr),
    .inc   (match_s),
    .q     (cnt)
  );

endmodule

// File: tb/tb_seq_match_fsm.sv
// Self-checking bench for seq_match_fsm.
// Four instances share one stimulus stream:
//   u0: defaults (W=2, N=3, PATTERN=1,2,2, OVERLAP=1, CNT_W=4)
//   u1: N=2, PATTERN=1,1, OVERLAP=1
//   u2: N=2, PATTERN=1,1, OVERLAP=0
//   u3: defaults with CNT_W=2
// Directed tables and sequences check hand-derived values.
// A random phase compares all four instances against a queue-based model.
module tb_seq_match_fsm;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       in_valid;
  logic [1:0] sym_in;
  logic       cnt_clr;

  logic       hit0, hit1, hit2, hit3;
  logic [3:0] cnt0, cnt1, cnt2;
  logic [1:0] cnt3;
  logic [1:0] fill0, fill1, fill2, fill3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_match_fsm #(.W(2), .N(3), .PATTERN(6'b01_10_10), .OVERLAP(1), .CNT_W(4)) u0 (
    .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in(sym_in), .cnt_clr(cnt_clr),
    .hit(hit0), .cnt(cnt0), .fill(fill0));
  seq_match_fsm #(.W(2), .N(2), .PATTERN(4'b01_01), .OVERLAP(1), .CNT_W(4)) u1 (
    .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in(sym_in), .cnt_clr(cnt_clr),
    .hit(hit1), .cnt(cnt1), .fill(fill1));
  seq_match_fsm #(.W(2), .N(2), .PATTERN(4'b01_01), .OVERLAP(0), .CNT_W(4)) u2 (
    .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in(sym_in), .cnt_clr(cnt_clr),
    .hit(hit2), .cnt(cnt2), .fill(fill2));
  seq_match_fsm #(.W(2), .N(3), .PATTERN(6'b01_10_10), .OVERLAP(1), .CNT_W(2)) u3 (
    .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in(sym_in), .cnt_clr(cnt_clr),
    .hit(hit3), .cnt(cnt3), .fill(fill3));

  // Reference model: per config, a queue of valid symbols seen since the
  // last discard (at most N long), the expected count, and the expected hit.
  int mn   [4] = '{3, 2, 2, 3};
  int mov  [4] = '{1, 1, 0, 1};
  int mmax [4] = '{15, 15, 15, 3};
  int mpat [4][3] = '{'{1, 2, 2}, '{1, 1, 0}, '{1, 1, 0}, '{1, 2, 2}};
  int mq   [4][$];
  int mcnt [4];
  int mhit [4];

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mq[k].delete();
      mcnt[k] = 0;
      mhit[k] = 0;
    end
  endtask

  task automatic model_step(input int v, input int s, input int c);
    for (int k = 0; k < 4; k++) begin
      int n  = mn[k];
      int sz = mq[k].size();
      bit m  = (v != 0) && (sz >= n - 1) && (s == mpat[k][n-1]);
      if (m) begin
        for (int j = 0; j < n - 1; j++) begin
          if (mq[k][sz-(n-1)+j] != mpat[k][j]) m = 1'b0;
        end
      end
      if (v != 0) begin
        mq[k].push_back(s);
        if (mq[k].size() > n) void'(mq[k].pop_front());
        if (m && mov[k] == 0) mq[k].delete();
      end
      if (c != 0) mcnt[k] = 0;
      else if (m && mcnt[k] < mmax[k]) mcnt[k] = mcnt[k] + 1;
      mhit[k] = m ? 1 : 0;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle (inputs set after the previous edge), then sample at +1.
  task automatic cycle(input int v, input int s, input int c);
    in_valid = v[0];
    sym_in   = s[1:0];
    cnt_clr  = c[0];
    @(posedge clk);
    model_step(v, s, c);
    #1;
    in_valid = 1'b0;
    sym_in   = 2'd0;
    cnt_clr  = 1'b0;
  endtask

  // Async reset pulse between edges. Outputs must clear before any edge.
  task automatic reset_pulse();
    clr_n = 1'b0;
    model_reset();
    #1;
    chk("rst_hit0", hit0, 0);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_fill0", fill0, 0);
    #6;
    clr_n = 1'b1;
  endtask

  typedef struct {
    int v; int s; int c;
    int eh; int ec; int ef;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int sat_exp [5] = '{1, 2, 3, 3, 3};
    int ov_h1 [4] = '{0, 1, 1, 1};
    int ov_c1 [4] = '{0, 1, 2, 3};
    int ov_h2 [4] = '{0, 1, 0, 1};
    int ov_c2 [4] = '{0, 1, 1, 2};
    int ov_f2 [4] = '{1, 0, 1, 0};

    // Stream 0,1,2,2,2, then gaps, then cnt_clr with and without a match.
    tbl = '{
      '{1,0,0, 0,0,1}, '{1,1,0, 0,0,2}, '{1,2,0, 0,0,3}, '{1,2,0, 1,1,3},
      '{1,2,0, 0,1,3}, '{1,1,0, 0,1,3}, '{0,0,0, 0,1,3}, '{0,0,0, 0,1,3},
      '{0,0,0, 0,1,3}, '{1,2,0, 0,1,3}, '{0,0,0, 0,1,3}, '{1,2,0, 1,2,3},
      '{0,0,1, 0,0,3}, '{1,1,0, 0,0,3}, '{1,2,0, 0,0,3}, '{1,2,1, 1,0,3},
      '{1,2,0, 0,0,3}
    };

    clr_n = 1'b0; in_valid = 1'b0; sym_in = 2'd0; cnt_clr = 1'b0;
    model_reset();
    #50;
    chk("reset_hit", hit0, 0);
    chk("reset_cnt", cnt0, 0);
    chk("reset_fill", fill0, 0);
    #50;
    clr_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven vectors on the default instance.
    foreach (tbl[i]) begin
      cycle(tbl[i].v, tbl[i].s, tbl[i].c);
      chk($sformatf("tbl%0d_hit", i), hit0, tbl[i].eh);
      chk($sformatf("tbl%0d_cnt", i), cnt0, tbl[i].ec);
      chk($sformatf("tbl%0d_fill", i), fill0, tbl[i].ef);
    end

    // Overlap versus non-overlap on the stream 1,1,1,1.
    reset_pulse();
    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, 0);
      chk($sformatf("ov1_hit%0d", i), hit1, ov_h1[i]);
      chk($sformatf("ov1_cnt%0d", i), cnt1, ov_c1[i]);
      chk($sformatf("ov0_hit%0d", i), hit2, ov_h2[i]);
      chk($sformatf("ov0_cnt%0d", i), cnt2, ov_c2[i]);
      chk($sformatf("ov0_fill%0d", i), fill2, ov_f2[i]);
    end

    // Saturation on the 2-bit counter, then a clear that coincides with a match.
    reset_pulse();
    for (int k = 0; k < 5; k++) begin
      cycle(1, 1, 0);
      cycle(1, 2, 0);
      cycle(1, 2, 0);
      chk($sformatf("sat_hit%0d", k), hit3, 1);
      chk($sformatf("sat_cnt%0d", k), cnt3, sat_exp[k]);
    end
    cycle(1, 1, 0);
    cycle(1, 2, 0);
    cycle(1, 2, 1);
    chk("satclr_hit", hit3, 1);
    chk("satclr_cnt", cnt3, 0);

    // Reset while hit is high, then reset in the middle of a sequence.
    reset_pulse();
    cycle(1, 1, 0);
    cycle(1, 2, 0);
    cycle(1, 2, 0);
    chk("pre_rst_hit", hit0, 1);
    chk("pre_rst_cnt", cnt0, 1);
    reset_pulse();
    cycle(1, 1, 0);
    cycle(1, 2, 0);
    chk("mid_fill", fill0, 2);
    reset_pulse();
    cycle(1, 2, 0);
    chk("mid_hit", hit0, 0);
    chk("mid_fill_after", fill0, 1);
    chk("mid_cnt", cnt0, 0);

    // Random stream checked against the model on all four instances.
    reset_pulse();
    for (int i = 0; i < 3000; i++) begin
      int v = ($urandom_range(0, 3) != 0) ? 1 : 0;
      int s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3))
                                           : (($urandom_range(0, 2) == 0) ? 1 : 2);
      int c = ($urandom_range(0, 49) == 0) ? 1 : 0;
      cycle(v, s, c);
      chk("rnd_hit0", hit0, mhit[0]);
      chk("rnd_hit1", hit1, mhit[1]);
      chk("rnd_hit2", hit2, mhit[2]);
      chk("rnd_hit3", hit3, mhit[3]);
      chk("rnd_cnt0", cnt0, mcnt[0]);
      chk("rnd_cnt1", cnt1, mcnt[1]);
      chk("rnd_cnt2", cnt2, mcnt[2]);
      chk("rnd_cnt3", cnt3, mcnt[3]);
      chk("rnd_fill0", fill0, mq[0].size());
      chk("rnd_fill1", fill1, mq[1].size());
      chk("rnd_fill2", fill2, mq[2].size());
      chk("rnd_fill3", fill3, mq[3].size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
